// File: rtl/audio_pwm_pkg.sv
// Shared constants and level arithmetic for the multi-channel audio PWM generator.
// Functions work on 32-bit containers; callers size the result to DATA_W.
package audio_pwm_pkg;

    // Midscale of a full 32-bit word; narrower widths shift it down.
    localparam logic [31:0] MIDSCALE  = 32'h8000_0000;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 (1-based) as a mask over lfsr[15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] midscale(input int w);
        return MIDSCALE >> (32 - w);
    endfunction

    function automatic logic [31:0] vol_scale(input logic signed [31:0] sample,
                                              input logic [31:0] vol,
                                              input int vol_w);
        logic [31:0] shift;
        shift = ((32'd1 << vol_w) - 32'd1) - vol;
        return sample >>> shift;
    endfunction

    function automatic logic [31:0] to_offset_binary(input logic [31:0] value, input int w);
        return value ^ (MIDSCALE >> (32 - w));
    endfunction

endpackage

// File: rtl/audio_pwm_chan.sv
// One PWM channel: shadow level, active level and registered compare output.
// Latency: pwm reflects count one clock late; no backpressure of its own.
// Backpressure: none; the top only strobes accept when the shadow is free.
module audio_pwm_chan
    import audio_pwm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int VOL_W  = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] sample,
    input  logic [VOL_W-1:0]  vol,
    input  logic              mute,
    input  logic              accept,
    input  logic              pending,
    input  logic              wrap,
    input  logic              dither_bit,
    input  logic [DATA_W-1:0] count,
    output logic              pwm
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

    logic [DATA_W-1:0] level;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] active;

    always_comb begin
        level = DATA_W'(to_offset_binary(vol_scale(32'(signed'(sample)), 32'(vol), VOL_W), DATA_W));
        if (mute) level = MID;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shadow <= '0;
            pwm    <= 1'b0;
        end else begin
            if (accept) shadow <= level;
            pwm <= (count < active);
        end
    end

`ifdef AUDIO_PWM_DITHER_EN
    // base keeps the undithered level so repeated periods do not accumulate dither.
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] src;
    logic [DATA_W:0]   sum;

    always_comb begin
        src = pending ? shadow : base;
        sum = {1'b0, src} + (DATA_W+1)'(dither_bit);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            base   <= MID;
            active <= MID;
        end else if (wrap) begin
            base   <= src;
            active <= sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        end
    end
`else
    logic unused_dither;
    assign unused_dither = dither_bit;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)               active <= MID;
        else if (wrap && pending) active <= shadow;
    end
`endif

endmodule

// File: rtl/audio_pwm_out.sv
// Multi-channel audio PWM: volume-scaled PCM frames to per-channel PWM; AUDIO_PWM_DITHER_EN adds LFSR dither.
// Latency: new levels take effect at the next period wrap; pwm output is one clock behind the counter.
// Backpressure: one-frame shadow; ready drops until the wrap, frames offered while busy are dropped and counted.
module audio_pwm_out
    import audio_pwm_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int VOL_W    = 3
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         sample_valid_in,
    input  logic [CHANNELS*DATA_W-1:0]   sample_in,
    input  logic [VOL_W-1:0]             vol_in,
    input  logic                         mute_in,
    output logic                         sample_ready_out,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start_out,
    output logic [7:0]                   overrun_count_out
);

    logic [DATA_W-1:0]   count;
    logic                pending;
    logic                wrap;
    logic                accept;
    logic [CHANNELS-1:0] dither_bits;

    assign wrap             = (count == '1);
    assign sample_ready_out = ~pending;
    assign accept           = sample_valid_in && !pending;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count             <= '0;
            pending           <= 1'b0;
            period_start_out  <= 1'b0;
            overrun_count_out <= '0;
        end else begin
            count            <= count + 1'b1;
            period_start_out <= wrap;
            // accept and a pending-clearing wrap are exclusive: accept needs pending low.
            if (accept)                pending <= 1'b1;
            else if (wrap && pending)  pending <= 1'b0;
            if (sample_valid_in && pending && overrun_count_out != 8'hFF)
                overrun_count_out <= overrun_count_out + 8'd1;
        end
    end

`ifdef AUDIO_PWM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)    lfsr <= LFSR_SEED;
        else if (wrap) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_dither
        assign dither_bits[c] = lfsr[c % 16];
    end
`else
    assign dither_bits = '0;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        audio_pwm_chan #(
            .DATA_W (DATA_W),
            .VOL_W  (VOL_W)
        ) u_chan (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .sample     (sample_in[c*DATA_W +: DATA_W]),
            .vol        (vol_in),
            .mute       (mute_in),
            .accept     (accept),
            .pending    (pending),
            .wrap       (wrap),
            .dither_bit (dither_bits[c]),
            .count      (count),
            .pwm        (pwm_out[c])
        );
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed and randomized bench for audio_pwm_out (DATA_W=8, CHANNELS=2, VOL_W=3, dither off).
module tb_audio_pwm_out;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        sample_valid_in = 1'b0;
    logic [15:0] sample_in = '0;
    logic [2:0]  vol_in = 3'd7;
    logic        mute_in = 1'b0;
    logic        sample_ready_out;
    logic [1:0]  pwm_out;
    logic        period_start_out;
    logic [7:0]  overrun_count_out;

    int compares = 0;
    int fails    = 0;
    int exp_lvl[2];
    int lvl_a[2];

    audio_pwm_out #(.DATA_W(8), .CHANNELS(2), .VOL_W(3)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .sample_valid_in   (sample_valid_in),
        .sample_in         (sample_in),
        .vol_in            (vol_in),
        .mute_in           (mute_in),
        .sample_ready_out  (sample_ready_out),
        .pwm_out           (pwm_out),
        .period_start_out  (period_start_out),
        .overrun_count_out (overrun_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compares++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: arithmetic shift is floor division by 2^(7-vol); offset binary adds 128.
    function automatic int model_level(input int s, input int vol, input bit mute);
        int d, q;
        if (mute) return 128;
        d = 1 << (7 - vol);
        q = s / d;
        if (s < 0 && (s % d) != 0) q = q - 1;
        return q + 128;
    endfunction

    function automatic int to_signed8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    task automatic wait_ps();
        int n = 0;
        while (period_start_out !== 1'b1 && n < 600) begin
            @(negedge clk_in);
            n++;
        end
        if (period_start_out !== 1'b1) check("period_start_timeout", 0, 1);
    endtask

    task automatic clocks_to_ps(input string tag);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (period_start_out !== 1'b1 && n < 600);
        check(tag, n, 256);
    endtask

    // Count high cycles over one full period starting at the next period_start.
    task automatic measure(input string tag);
        int h0 = 0;
        int h1 = 0;
        wait_ps();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_in);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
        end
        check({tag, "_ch0"}, h0, exp_lvl[0]);
        check({tag, "_ch1"}, h1, exp_lvl[1]);
    endtask

    task automatic drive(input int s0, input int s1, input int vol, input bit mute);
        logic [31:0] a, b;
        a = s0;
        b = s1;
        sample_in = {b[7:0], a[7:0]};
        vol_in    = 3'(vol);
        mute_in   = mute;
    endtask

    task automatic send_frame(input int s0, input int s1, input int vol, input bit mute);
        drive(s0, s1, vol, mute);
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
    endtask

    initial begin
        // Reset state and first period.
        repeat (3) @(negedge clk_in);
        check("rst_pwm", pwm_out, 0);
        check("rst_ready", sample_ready_out, 1);
        check("rst_overrun", overrun_count_out, 0);
        check("rst_ps", period_start_out, 0);
        rst_in = 1'b0;
        clocks_to_ps("first_ps_after_release");
        exp_lvl[0] = 128;
        exp_lvl[1] = 128;
        measure("midscale");

        // Asynchronous reset mid-period.
        repeat (100) @(negedge clk_in);
        check("pre_reset_pwm", pwm_out, 2'b11);
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_pwm", pwm_out, 0);
        check("async_rst_ready", sample_ready_out, 1);
        check("async_rst_overrun", overrun_count_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        clocks_to_ps("ps_after_mid_reset");

        // Midscale / full negative.
        send_frame(0, -128, 7, 0);
        exp_lvl[0] = model_level(0, 7, 0);
        exp_lvl[1] = model_level(-128, 7, 0);
        measure("zero_and_min");

        // Full scale and volume shift.
        send_frame(127, 50, 7, 0);
        exp_lvl[0] = model_level(127, 7, 0);
        exp_lvl[1] = model_level(50, 7, 0);
        measure("max_vol7");
        send_frame(127, -3, 5, 0);
        exp_lvl[0] = model_level(127, 5, 0);
        exp_lvl[1] = model_level(-3, 5, 0);
        measure("max_vol5");

        // Two frames in one period: second dropped.
        wait_ps();
        send_frame(100, -100, 6, 0);
        check("ready_after_accept", sample_ready_out, 0);
        send_frame(-50, 20, 7, 0);
        check("overrun_one", overrun_count_out, 1);
        repeat (250) @(negedge clk_in);
        check("ready_low_until_wrap", sample_ready_out, 0);
        lvl_a[0] = model_level(100, 6, 0);
        lvl_a[1] = model_level(-100, 6, 0);
        exp_lvl = lvl_a;
        wait_ps();
        check("ready_after_wrap", sample_ready_out, 1);
        measure("drop_keeps_first");

        // Saturating overrun counter.
        drive(100, -100, 6, 0);
        sample_valid_in = 1'b1;
        repeat (600) @(negedge clk_in);
        sample_valid_in = 1'b0;
        check("overrun_saturated", overrun_count_out, 255);
        measure("after_saturation");

        // Frame presented on the wrap cycle.
        wait_ps();
        repeat (255) @(negedge clk_in);
        send_frame(64, -64, 7, 0);
        check("wrap_frame_ready", sample_ready_out, 0);
        measure("wrap_old_level");
        exp_lvl[0] = model_level(64, 7, 0);
        exp_lvl[1] = model_level(-64, 7, 0);
        measure("wrap_new_level");

        // Mute, then repeat for three periods without new frames.
        send_frame(-128, 30, 7, 1);
        exp_lvl[0] = 128;
        exp_lvl[1] = 128;
        measure("mute_p1");
        measure("mute_p2");
        measure("mute_p3");

        // Randomized frames at random offsets within the period.
        for (int it = 0; it < 10; it++) begin
            int s0, s1, v;
            bit m;
            wait_ps();
            repeat ($urandom_range(1, 200)) @(negedge clk_in);
            s0 = to_signed8($urandom_range(0, 255));
            s1 = to_signed8($urandom_range(0, 255));
            v  = $urandom_range(0, 7);
            m  = ($urandom_range(0, 7) == 0);
            send_frame(s0, s1, v, m);
            exp_lvl[0] = model_level(s0, v, m);
            exp_lvl[1] = model_level(s1, v, m);
            measure($sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
